// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, encodings and helpers for uart_tx_multi (UART_TX_BREAK_EN adds the BREAK state)
package uart_pkg;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_HOLD, ST_BREAK
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_HOLD
    } tx_state_e;
`endif

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int MIN_CLKS_PER_BIT = 2;

    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        case (dbits)
            DBITS_5: return 8'h1F;
            DBITS_6: return 8'h3F;
            DBITS_7: return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                        input logic [1:0] par);
        logic x;
        x = ^(data & data_mask(dbits));
        case (par)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - single-clock byte FIFO with registered read data, level, full and empty
module uart_tx_fifo #(
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [7:0]    rd_data_q;
    logic          do_rd, do_wr;

    assign full_o    = (level_q == LW'(FIFO_DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = rd_data_q;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_multi.sv
// rtl/uart_tx_multi.sv - multi-format UART transmitter with FIFO and RS-485 enable (UART_TX_BREAK_EN adds line break)
module uart_tx_multi
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16,
    parameter int EN_HOLD_CLKS = 8
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [DIV_W-1:0]          i_Clks_Per_Bit,
    input  logic [1:0]                i_Data_Bits,
    input  logic [1:0]                i_Parity,
    input  logic                      i_Stop_Bits,
    input  logic                      i_Tx_DV,
    input  logic [7:0]                i_Tx_Byte,
`ifdef UART_TX_BREAK_EN
    input  logic                      i_Break,
`endif
    output logic                      o_Tx_Ready,
    output logic                      o_Tx_Serial,
    output logic                      o_Tx_Enable,
    output logic                      o_Tx_Active,
    output logic                      o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Level
);

    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(EN_HOLD_CLKS - 1);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(MIN_CLKS_PER_BIT);

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, n_q, n_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       dbits_q, dbits_d, par_q, par_d;
    logic             stop_q, stop_d, par_bit_q, par_bit_d, done_q, done_d;
    logic             bit_tick, start_frame, fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata;
`ifdef UART_TX_BREAK_EN
    logic             brk_mark_q, brk_mark_d, brk_min_q, brk_min_d, enter_break;
`endif

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (i_Clock),
        .rst_i     (i_Reset),
        .wr_en_i   (i_Tx_DV),
        .wr_data_i (i_Tx_Byte),
        .rd_en_i   (start_frame),
        .rd_data_o (fifo_rdata),
        .level_o   (o_Fifo_Level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bit_tick = (cnt_q == n_q - DIV_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + DIV_W'(1);
        n_d         = n_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        dbits_d     = dbits_q;
        par_d       = par_q;
        stop_d      = stop_q;
        par_bit_d   = par_bit_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_mark_d  = brk_mark_q;
        brk_min_d   = brk_min_q;
        enter_break = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef UART_TX_BREAK_EN
                if (i_Break) enter_break = 1'b1; else
`endif
                if (!fifo_empty) start_frame = 1'b1;
            end
            ST_START: if (bit_tick) begin
                // The popped byte is valid in the FIFO read register from the first START clock.
                cnt_d     = '0;
                bit_d     = '0;
                shift_d   = fifo_rdata & data_mask(dbits_q);
                par_bit_d = parity_bit(fifo_rdata, dbits_q, par_q);
                state_d   = ST_DATA;
            end
            ST_DATA: if (bit_tick) begin
                cnt_d   = '0;
                shift_d = shift_q >> 1;
                if (bit_q == ({2'b00, dbits_q} + 4'd4)) begin
                    bit_d   = '0;
                    state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            ST_PARITY: if (bit_tick) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_STOP;
            end
            ST_STOP: if (bit_tick) begin
                cnt_d = '0;
                if (bit_q[0] == stop_q) begin
                    done_d = 1'b1;
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_d = ST_HOLD;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            ST_HOLD: begin
`ifdef UART_TX_BREAK_EN
                if (i_Break) enter_break = 1'b1; else
`endif
                if (!fifo_empty) start_frame = 1'b1;
                else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (!brk_mark_q) begin
                    // bit_q counts completed bit periods of the low phase, saturating at the 11th.
                    if (bit_tick) begin
                        cnt_d = '0;
                        if (bit_q == 4'd10) brk_min_d = 1'b1;
                        else                bit_d = bit_q + 4'd1;
                    end
                    if ((brk_min_q || (bit_tick && bit_q == 4'd10)) && !i_Break) begin
                        brk_mark_d = 1'b1;
                        cnt_d      = '0;
                    end
                end else if (bit_tick) begin
                    cnt_d      = '0;
                    brk_mark_d = 1'b0;
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_TX_BREAK_EN
        if (enter_break) begin
            state_d    = ST_BREAK;
            n_d        = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
            cnt_d      = '0;
            bit_d      = '0;
            brk_mark_d = 1'b0;
            brk_min_d  = 1'b0;
        end
`endif
        if (start_frame) begin
            state_d = ST_START;
            cnt_d   = '0;
            n_d     = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
            dbits_d = i_Data_Bits;
            par_d   = i_Parity;
            stop_d  = i_Stop_Bits;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= MIN_DIV;
            bit_q     <= '0;
            shift_q   <= '0;
            dbits_q   <= DBITS_8;
            par_q     <= PAR_NONE;
            stop_q    <= 1'b0;
            par_bit_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= 1'b0;
            brk_min_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dbits_q   <= dbits_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            par_bit_q <= par_bit_d;
            done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= brk_mark_d;
            brk_min_q  <= brk_min_d;
`endif
        end
    end

    always_comb begin
        o_Tx_Serial = 1'b1;
        case (state_q)
            ST_START:  o_Tx_Serial = 1'b0;
            ST_DATA:   o_Tx_Serial = shift_q[0];
            ST_PARITY: o_Tx_Serial = par_bit_q;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  o_Tx_Serial = brk_mark_q;
`endif
            default:   o_Tx_Serial = 1'b1;
        endcase
    end

    assign o_Tx_Enable = (state_q != ST_IDLE);
    assign o_Tx_Active = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_multi.sv
// tb/tb_uart_tx_multi.sv - randomized self-checking bench for uart_tx_multi against a frame-level model
module tb_uart_tx_multi;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int EN_HOLD    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] clks_per_bit = 16'd4;
    logic [1:0]       data_bits = 2'b11;
    logic [1:0]       parity = 2'b00;
    logic             stop_bits = 1'b0;
    logic             tx_dv = 1'b0;
    logic [7:0]       tx_byte = 8'h00;
`ifdef UART_TX_BREAK_EN
    logic             brk = 1'b0;
`endif
    logic             tx_ready, tx_serial, tx_enable, tx_active, tx_done;
    logic [4:0]       fifo_level;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit exp_bits[$];

    uart_tx_multi #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .EN_HOLD_CLKS(EN_HOLD)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Clks_Per_Bit (clks_per_bit),
        .i_Data_Bits    (data_bits),
        .i_Parity       (parity),
        .i_Stop_Bits    (stop_bits),
        .i_Tx_DV        (tx_dv),
        .i_Tx_Byte      (tx_byte),
`ifdef UART_TX_BREAK_EN
        .i_Break        (brk),
`endif
        .o_Tx_Ready     (tx_ready),
        .o_Tx_Serial    (tx_serial),
        .o_Tx_Enable    (tx_enable),
        .o_Tx_Active    (tx_active),
        .o_Tx_Done      (tx_done),
        .o_Fifo_Level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line bits of one frame, one entry per bit period.
    task automatic build_frame(input logic [7:0] b, input int dcode, input int par, input bit stop2);
        int nbits, ones;
        nbits = 5 + dcode;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (par == 1) exp_bits.push_back(bit'(ones % 2));
        if (par == 2) exp_bits.push_back(bit'(1 - ones % 2));
        if (par == 3) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_dv = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    task automatic wait_start(input int max, output int waited);
        waited = 0;
        while (tx_serial !== 1'b0 && waited < max) begin
            @(negedge clk);
            waited++;
        end
        check_eq("start_seen", 32'(tx_serial == 1'b0), 32'd1);
    endtask

    // Called on the clock where the start bit is first visible.
    task automatic check_frame(input string tag, input logic [7:0] b, input int dcode,
                               input int par, input bit stop2, input int div);
        int n;
        n = (div < 2) ? 2 : div;
        build_frame(b, dcode, par, stop2);
        for (int i = 0; i < exp_bits.size() * n; i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, i), 32'({tx_active, tx_enable, tx_serial}),
                     32'({2'b11, exp_bits[i / n]}));
        end
    endtask

    task automatic check_hold(input string tag);
        @(negedge clk);
        check_eq({tag, "_done"}, 32'({tx_done, tx_active, tx_enable}), 32'b101);
        repeat (EN_HOLD - 1) @(negedge clk);
        check_eq({tag, "_hold"}, 32'({tx_done, tx_enable, tx_serial}), 32'b011);
        repeat (2) @(negedge clk);
        check_eq({tag, "_idle"}, 32'({tx_enable, tx_serial}), 32'b01);
    endtask

    task automatic set_cfg(input int div, input int dcode, input int par, input bit stop2);
        clks_per_bit = DIV_W'(div);
        data_bits = 2'(dcode);
        parity = 2'(par);
        stop_bits = stop2;
    endtask

    initial begin
        int w, d0, div, dc, par;
        bit st;
        logic [7:0] b;
        logic [7:0] bytes [17];

        repeat (3) @(negedge clk);
        check_eq("reset_out", 32'({tx_serial, tx_enable, tx_active, tx_done, tx_ready}), 32'b10001);
        check_eq("reset_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_out", 32'({tx_serial, tx_enable, tx_active}), 32'b100);

        set_cfg(4, 3, 0, 1'b0);
        push(8'hA5);
        wait_start(20, w);
        check_eq("8N1_latency", 32'(w), 32'd1);
        check_frame("8N1", 8'hA5, 3, 0, 1'b0, 4);
        check_hold("8N1");

        set_cfg(5, 2, 1, 1'b1);
        push(8'h41);
        wait_start(20, w);
        check_frame("7E2", 8'h41, 2, 1, 1'b1, 5);
        check_hold("7E2");

        set_cfg(3, 0, 2, 1'b0);
        push(8'hFF);
        wait_start(20, w);
        check_frame("5O1", 8'hFF, 0, 2, 1'b0, 3);
        check_hold("5O1");

        // 17 back-to-back pushes plus one dropped push while full.
        set_cfg(2, 3, 0, 1'b0);
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        d0 = done_cnt;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    tx_dv = 1'b1;
                    tx_byte = bytes[i];
                    @(negedge clk);
                end
                check_eq("full_level", 32'(fifo_level), 32'd16);
                check_eq("full_ready", 32'(tx_ready), 32'd0);
                tx_byte = 8'hEE;
                @(negedge clk);
                tx_dv = 1'b0;
                check_eq("drop_level", 32'(fifo_level), 32'd16);
            end
            begin
                int ws;
                wait_start(40, ws);
                for (int i = 0; i < 17; i++) begin
                    if (i > 0) @(negedge clk);
                    check_frame($sformatf("b2b%0d", i), bytes[i], 3, 0, 1'b0, 2);
                end
            end
        join
        repeat (3) @(negedge clk);
        check_eq("b2b_done_cnt", 32'(done_cnt - d0), 32'd17);
        check_eq("b2b_level", 32'(fifo_level), 32'd0);
        repeat (EN_HOLD + 2) @(negedge clk);

        // Reset in the middle of the data bits, with a second byte queued.
        set_cfg(4, 3, 0, 1'b0);
        push(8'h3C);
        push(8'h55);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_out", 32'({tx_serial, tx_enable, tx_active, tx_ready}), 32'b1001);
        check_eq("midrst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("postrst_idle", 32'({tx_serial, tx_enable}), 32'b10);
        push(8'h3C);
        wait_start(20, w);
        check_eq("postrst_latency", 32'(w), 32'd1);
        check_frame("postrst", 8'h3C, 3, 0, 1'b0, 4);
        check_hold("postrst");

        // Random formats; inputs are scrambled once the frame has started to prove the latch.
        for (int k = 0; k < 12; k++) begin
            div = $urandom_range(0, 6);
            dc = $urandom_range(0, 3);
            par = $urandom_range(0, 3);
            st = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            set_cfg(div, dc, par, st);
            push(b);
            wait_start(20, w);
            check_eq($sformatf("rnd%0d_latency", k), 32'(w), 32'd1);
            set_cfg($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
            check_frame($sformatf("rnd%0d", k), b, dc, par, st, div);
            check_hold($sformatf("rnd%0d", k));
        end

`ifdef UART_TX_BREAK_EN
        set_cfg(4, 3, 0, 1'b0);
        @(negedge clk);
        brk = 1'b1;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            check_eq($sformatf("brk_low[%0d]", i), 32'({tx_enable, tx_serial}), 32'b10);
            if (i == 0) begin
                tx_dv = 1'b1;
                tx_byte = 8'h55;
            end
            if (i == 1) tx_dv = 1'b0;
            if (i == 9) brk = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("brk_mark[%0d]", i), 32'({tx_enable, tx_serial}), 32'b11);
        end
        @(negedge clk);
        check_frame("brk_frame", 8'h55, 3, 0, 1'b0, 4);
        check_hold("brk_frame");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
